// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM.
// One access at a time; read data captured SRAM_LATENCY edges after the strobe.
module sram_arbiter #(
  parameter int SRAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        sram_wen,
  output logic        sram_sense_en,
  output logic [11:0] sram_addr,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        last;
  logic [3:0]  cnt;
  logic        grant;
  logic        pick;
  logic        pick_we;

  // last == 1 means port 1 was granted last, so port 0 wins a tie
  assign pick    = (req0 & req1) ? ~last : req1;
  assign pick_we = pick ? we1 : we0;
  assign grant   = (state == IDLE) & (req0 | req1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nx = pick_we ? WRITE : READ;
        end
      end
      WRITE: state_nx = DONE;
      READ:  state_nx = WAIT;
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sram_wen      = (state == WRITE);
    sram_sense_en = (state == READ);
    ack0          = (state == DONE) & ~owner;
    ack1          = (state == DONE) & owner;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= 4'd0;
      sram_addr <= 12'd0;
      sram_din  <= 8'd0;
      rdata0    <= 8'd0;
      rdata1    <= 8'd0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner     <= pick;
        last      <= pick;
        sram_addr <= pick ? addr1 : addr0;
        sram_din  <= pick ? wdata1 : wdata0;
      end
      if (state == READ) begin
        cnt <= 4'(SRAM_LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == WAIT && cnt == 4'd0) begin
        if (owner) begin
          rdata1 <= sram_dout;
        end else begin
          rdata0 <= sram_dout;
        end
      end
    end
  end

endmodule
